// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared defaults and forwarding-source encoding for the
//               bypassing register file.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR  = 0;

    typedef enum logic [2:0] {
        SRC_EX = 3'd0,
        SRC_ME = 3'd1,
        SRC_WB = 3'd2,
        SRC_LW = 3'd3,
        SRC_RF = 3'd4
    } fwd_src_t;

endpackage
`default_nettype wire

// File: rtl/rf_bypass_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_bypass_port
// Description : One read port: youngest-first stage compare, data mux and
//               the port's contribution to the pipeline stall.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_bypass_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_rd_use,
    input  logic [DATA_W-1:0] i_arr_data,
    input  logic              i_arr_pend,
    input  logic              i_ex_we,
    input  logic [ADDR_W-1:0] i_ex_waddr,
    input  logic [DATA_W-1:0] i_ex_wdata,
    input  logic              i_ex_dvalid,
    input  logic              i_me_we,
    input  logic [ADDR_W-1:0] i_me_waddr,
    input  logic [DATA_W-1:0] i_me_wdata,
    input  logic              i_me_dvalid,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_waddr,
    input  logic [DATA_W-1:0] i_wb_wdata,
    input  logic              i_lw_we,
    input  logic [ADDR_W-1:0] i_lw_waddr,
    input  logic [DATA_W-1:0] i_lw_wdata,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_stall,
    output fwd_src_t          o_src
);

    logic              w_is_zero;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;

    always_comb begin
        w_is_zero = (ZERO_REG != 0) && (i_rd_addr == ADDR_W'(ZERO_ADDR));
        o_src     = SRC_RF;
        w_data    = i_arr_data;
        w_ready   = 1'b1;

        if (i_ex_we && (i_ex_waddr == i_rd_addr)) begin
            o_src   = SRC_EX;
            w_data  = i_ex_wdata;
            w_ready = i_ex_dvalid;
        end else if (i_me_we && (i_me_waddr == i_rd_addr)) begin
            o_src   = SRC_ME;
            w_data  = i_me_wdata;
            w_ready = i_me_dvalid;
        end else if (i_wb_we && (i_wb_waddr == i_rd_addr)) begin
            o_src   = SRC_WB;
            w_data  = i_wb_wdata;
        end else if (i_lw_we && (i_lw_waddr == i_rd_addr)) begin
            o_src   = SRC_LW;
            w_data  = i_lw_wdata;
        end

        // The pending bit only matters when no in-flight stage supplies the value
        o_rd_data = w_is_zero ? '0 : w_data;
        o_stall   = i_rd_use && !w_is_zero &&
                    (!w_ready || ((o_src == SRC_RF) && i_arr_pend));
    end

endmodule
`default_nettype wire

// File: rtl/regfile_bypass_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bypass_sb
// Description : Parametrised forwarding register file with a pending-write
//               scoreboard for long-latency results. Optional stall counter
//               enabled by defining RF_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bypass_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_use,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     stall,
    input  logic                     iss_valid,
    input  logic                     iss_long,
    input  logic [ADDR_W-1:0]        iss_waddr,
    input  logic                     ex_we,
    input  logic [ADDR_W-1:0]        ex_waddr,
    input  logic [DATA_W-1:0]        ex_wdata,
    input  logic                     ex_dvalid,
    input  logic                     me_we,
    input  logic [ADDR_W-1:0]        me_waddr,
    input  logic [DATA_W-1:0]        me_wdata,
    input  logic                     me_dvalid,
    input  logic                     wb_we,
    input  logic [ADDR_W-1:0]        wb_waddr,
    input  logic [DATA_W-1:0]        wb_wdata,
    input  logic                     lw_we,
    input  logic [ADDR_W-1:0]        lw_waddr,
    input  logic [DATA_W-1:0]        lw_wdata
`ifdef RF_PERF_CNT_EN
    ,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;

    logic              w_wb_ok;
    logic              w_lw_ok;
    logic              w_pend_set;
    logic [NUM_RD-1:0] w_port_stall;
    fwd_src_t          w_dbg_src_unused [NUM_RD];

    always_comb begin
        w_wb_ok    = wb_we && !((ZERO_REG != 0) && (wb_waddr == ADDR_W'(ZERO_ADDR)));
        w_lw_ok    = lw_we && !((ZERO_REG != 0) && (lw_waddr == ADDR_W'(ZERO_ADDR)));
        w_pend_set = iss_valid && !stall && iss_long &&
                     !((ZERO_REG != 0) && (iss_waddr == ADDR_W'(ZERO_ADDR)));
    end

    // WB is assigned after LW so the pipeline-ordered result wins a collision;
    // likewise a new issue's set overrides a same-address late-write clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
            r_pend <= '0;
        end else begin
            if (w_lw_ok) begin
                r_mem[lw_waddr] <= lw_wdata;
            end
            if (w_wb_ok) begin
                r_mem[wb_waddr] <= wb_wdata;
            end
            if (lw_we) begin
                r_pend[lw_waddr] <= 1'b0;
            end
            if (w_pend_set) begin
                r_pend[iss_waddr] <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
            logic [ADDR_W-1:0] w_addr;
            assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];

            rf_bypass_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG)
            ) u_port (
                .i_rd_addr   (w_addr),
                .i_rd_use    (rd_use[gi]),
                .i_arr_data  (r_mem[w_addr]),
                .i_arr_pend  (r_pend[w_addr]),
                .i_ex_we     (ex_we),
                .i_ex_waddr  (ex_waddr),
                .i_ex_wdata  (ex_wdata),
                .i_ex_dvalid (ex_dvalid),
                .i_me_we     (me_we),
                .i_me_waddr  (me_waddr),
                .i_me_wdata  (me_wdata),
                .i_me_dvalid (me_dvalid),
                .i_wb_we     (wb_we),
                .i_wb_waddr  (wb_waddr),
                .i_wb_wdata  (wb_wdata),
                .i_lw_we     (lw_we),
                .i_lw_waddr  (lw_waddr),
                .i_lw_wdata  (lw_wdata),
                .o_rd_data   (rd_data[gi*DATA_W +: DATA_W]),
                .o_stall     (w_port_stall[gi]),
                .o_src       (w_dbg_src_unused[gi])
            );
        end
    endgenerate

    assign stall = |w_port_stall;

`ifdef RF_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_wb_ok && w_lw_ok && (wb_waddr == lw_waddr)))
                else $error("regfile_bypass_sb: WB and LW write the same register in one cycle");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_bypass_sb
// Description : Self-checking bench: directed vectors, multi-cycle hazard
//               sequences and randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_bypass_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR-1:0]     rd_use;
    logic [NR*DW-1:0]  rd_data;
    logic              stall;
    logic              iss_valid, iss_long;
    logic [AW-1:0]     iss_waddr;
    logic              ex_we, ex_dvalid, me_we, me_dvalid, wb_we, lw_we;
    logic [AW-1:0]     ex_waddr, me_waddr, wb_waddr, lw_waddr;
    logic [DW-1:0]     ex_wdata, me_wdata, wb_wdata, lw_wdata;
`ifdef RF_PERF_CNT_EN
    logic [31:0]       stall_cycles;
`endif

    always #5 clk = ~clk;

    regfile_bypass_sb #(
        .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR), .ZERO_REG (1)
    ) dut (
        .clk (clk), .rst (rst),
        .rd_addr (rd_addr), .rd_use (rd_use), .rd_data (rd_data), .stall (stall),
        .iss_valid (iss_valid), .iss_long (iss_long), .iss_waddr (iss_waddr),
        .ex_we (ex_we), .ex_waddr (ex_waddr), .ex_wdata (ex_wdata), .ex_dvalid (ex_dvalid),
        .me_we (me_we), .me_waddr (me_waddr), .me_wdata (me_wdata), .me_dvalid (me_dvalid),
        .wb_we (wb_we), .wb_waddr (wb_waddr), .wb_wdata (wb_wdata),
        .lw_we (lw_we), .lw_waddr (lw_waddr), .lw_wdata (lw_wdata)
`ifdef RF_PERF_CNT_EN
        , .stall_cycles (stall_cycles)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rd_addr = '0; rd_use = '0;
        iss_valid = 0; iss_long = 0; iss_waddr = '0;
        ex_we = 0; ex_waddr = '0; ex_wdata = '0; ex_dvalid = 1;
        me_we = 0; me_waddr = '0; me_wdata = '0; me_dvalid = 1;
        wb_we = 0; wb_waddr = '0; wb_wdata = '0;
        lw_we = 0; lw_waddr = '0; lw_wdata = '0;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a, input logic u);
        rd_addr[p*AW +: AW] = a;
        rd_use[p]           = u;
    endtask

    function automatic logic [DW-1:0] pdata(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string         name;
        logic [AW-1:0] ra;  logic ru;
        logic ex_we_v; logic [AW-1:0] ex_a; logic [DW-1:0] ex_d; logic ex_v;
        logic me_we_v; logic [AW-1:0] me_a; logic [DW-1:0] me_d; logic me_v;
        logic wb_we_v; logic [AW-1:0] wb_a; logic [DW-1:0] wb_d;
        logic lw_we_v; logic [AW-1:0] lw_a; logic [DW-1:0] lw_d;
        logic [DW-1:0] exp_d; logic exp_s;
    } vec_t;

    vec_t vecs[11];

    // ---------------- reference model ----------------
    logic [DW-1:0] m_rf   [32];
    bit            m_pend [32];

    // Oldest source first; each younger matching stage overrides the older one.
    task automatic model_port(input logic [AW-1:0] a, input bit u,
                              output logic [DW-1:0] d, output bit s);
        bit            hit [4];
        bit            ok  [4];
        logic [DW-1:0] dat [4];
        hit[0] = ex_we && ex_waddr == a; ok[0] = ex_dvalid; dat[0] = ex_wdata;
        hit[1] = me_we && me_waddr == a; ok[1] = me_dvalid; dat[1] = me_wdata;
        hit[2] = wb_we && wb_waddr == a; ok[2] = 1'b1;      dat[2] = wb_wdata;
        hit[3] = lw_we && lw_waddr == a; ok[3] = 1'b1;      dat[3] = lw_wdata;
        d = m_rf[a];
        s = u && m_pend[a];
        for (int k = 3; k >= 0; k--) begin
            if (hit[k]) begin
                d = dat[k];
                s = u && !ok[k];
            end
        end
        if (a == 0) begin
            d = '0;
            s = 0;
        end
    endtask

    initial begin
        logic [DW-1:0] ed [NR];
        bit            es [NR];
        bit            est;

        idle();
        rst = 1;
        repeat (2) @(posedge clk);

        // reset state and basic write-then-read
        @(negedge clk);
        rst = 0;
        rd(0, 5, 1); rd(1, 6, 1);
        #2;
        chk("reset_d0", pdata(0), 32'h0);
        chk("reset_d1", pdata(1), 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        idle(); rd(0, 5, 1);
        wb_we = 1; wb_waddr = 5; wb_wdata = 32'h1234;
        #2 chk("wb_fwd_r5", pdata(0), 32'h1234);
        @(negedge clk);
        idle(); rd(0, 5, 1);
        #2 chk("arr_r5", pdata(0), 32'h1234);

        // forwarding table
        vecs[0]  = '{"fwd_ex",    3,1, 1,3,32'hA,1,  1,3,32'hB,1,  1,3,32'hC, 0,0,0,       32'hA,0};
        vecs[1]  = '{"fwd_me",    3,1, 0,3,32'hA,1,  1,3,32'hB,1,  1,3,32'hC, 0,0,0,       32'hB,0};
        vecs[2]  = '{"fwd_wb",    3,1, 0,3,32'hA,1,  0,3,32'hB,1,  1,3,32'hC, 0,0,0,       32'hC,0};
        vecs[3]  = '{"fwd_lw",    3,1, 0,0,0,1,      0,0,0,1,      0,0,0,     1,3,32'hD,   32'hD,0};
        vecs[4]  = '{"ld_use",    7,1, 1,7,32'h99,0, 0,0,0,1,      0,0,0,     0,0,0,       32'h99,1};
        vecs[5]  = '{"ld_nouse",  7,0, 1,7,32'h99,0, 0,0,0,1,      0,0,0,     0,0,0,       32'h99,0};
        vecs[6]  = '{"ex_over_me",7,1, 1,7,32'h11,1, 1,7,32'h22,0, 0,0,0,     0,0,0,       32'h11,0};
        vecs[7]  = '{"me_notrdy", 7,1, 1,8,32'h11,0, 1,7,32'h22,0, 0,0,0,     0,0,0,       32'h22,1};
        vecs[8]  = '{"zero_reg",  0,1, 1,0,32'hFF,0, 1,0,32'hEE,1, 1,0,32'hDD,0,0,0,       32'h0,0};
        vecs[9]  = '{"arr_only",  5,1, 0,0,0,1,      0,0,0,1,      0,0,0,     0,0,0,       32'h1234,0};
        vecs[10] = '{"lw_vs_arr", 4,1, 0,0,0,1,      1,9,32'h5,1,  0,0,0,     1,4,32'h88,  32'h88,0};

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            idle();
            rd(0, vecs[i].ra, vecs[i].ru);
            ex_we = vecs[i].ex_we_v; ex_waddr = vecs[i].ex_a; ex_wdata = vecs[i].ex_d; ex_dvalid = vecs[i].ex_v;
            me_we = vecs[i].me_we_v; me_waddr = vecs[i].me_a; me_wdata = vecs[i].me_d; me_dvalid = vecs[i].me_v;
            wb_we = vecs[i].wb_we_v; wb_waddr = vecs[i].wb_a; wb_wdata = vecs[i].wb_d;
            lw_we = vecs[i].lw_we_v; lw_waddr = vecs[i].lw_a; lw_wdata = vecs[i].lw_d;
            #2;
            chk({vecs[i].name, "_data"},  pdata(0), vecs[i].exp_d);
            chk({vecs[i].name, "_stall"}, {31'b0, stall}, {31'b0, vecs[i].exp_s});
        end

        // load-use resolved one cycle later from ME
        @(negedge clk);
        idle(); rd(0, 7, 1);
        ex_we = 1; ex_waddr = 7; ex_dvalid = 0;
        #2 chk("lu_stall", {31'b0, stall}, 32'h1);
        @(negedge clk);
        idle(); rd(0, 7, 1);
        me_we = 1; me_waddr = 7; me_wdata = 32'h55; me_dvalid = 1;
        #2;
        chk("lu_resolved_stall", {31'b0, stall}, 32'h0);
        chk("lu_resolved_data", pdata(0), 32'h55);

        // long op: pend until late write; a stalled issue must not set pend
        @(negedge clk);
        idle(); iss_valid = 1; iss_long = 1; iss_waddr = 9;
        #2 chk("iss_nostall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        idle(); rd(0, 9, 1);
        #2 chk("long_stall1", {31'b0, stall}, 32'h1);
        @(negedge clk);
        idle(); rd(0, 9, 1);
        iss_valid = 1; iss_long = 1; iss_waddr = 10;
        #2 chk("long_stall2", {31'b0, stall}, 32'h1);
        @(negedge clk);
        idle(); rd(0, 9, 1);
        lw_we = 1; lw_waddr = 9; lw_wdata = 32'hDEAD;
        #2;
        chk("lw_fwd_data", pdata(0), 32'hDEAD);
        chk("lw_fwd_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        idle(); rd(0, 9, 1); rd(1, 10, 1);
        #2;
        chk("lw_arr_data", pdata(0), 32'hDEAD);
        chk("stalled_iss_nopend", {31'b0, stall}, 32'h0);

        // same-cycle clear and re-issue: set wins
        @(negedge clk);
        idle(); iss_valid = 1; iss_long = 1; iss_waddr = 9;
        @(negedge clk);
        idle(); rd(0, 9, 1);
        lw_we = 1; lw_waddr = 9; lw_wdata = 32'hBEEF;
        iss_valid = 1; iss_long = 1; iss_waddr = 9;
        #2 chk("reissue_nostall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        idle(); rd(0, 9, 1);
        #2 chk("set_wins", {31'b0, stall}, 32'h1);
        @(negedge clk);
        idle(); lw_we = 1; lw_waddr = 9; lw_wdata = 32'h1;

        // register 0
        @(negedge clk);
        idle(); rd(0, 0, 1);
        wb_we = 1; wb_waddr = 0; wb_wdata = 32'hFF;
        iss_valid = 1; iss_long = 1; iss_waddr = 0;
        #2;
        chk("r0_wb_data", pdata(0), 32'h0);
        chk("r0_wb_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        idle(); rd(0, 0, 1);
        #2;
        chk("r0_data", pdata(0), 32'h0);
        chk("r0_stall", {31'b0, stall}, 32'h0);

`ifdef RF_PERF_CNT_EN
        do_reset();
        #2 chk("cnt_reset", stall_cycles, 32'h0);
        @(negedge clk);
        idle(); iss_valid = 1; iss_long = 1; iss_waddr = 12;
        @(negedge clk);
        idle(); rd(0, 12, 1);
        repeat (3) @(negedge clk);
        #2 chk("cnt_three", stall_cycles, 32'd3);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #2;
        chk("cnt_rst_mid", stall_cycles, 32'h0);
        chk("pend_rst_mid", {31'b0, stall}, 32'h0);
`endif

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 32; k++) begin
            m_rf[k]   = '0;
            m_pend[k] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < NR; p++) begin
                rd(p, AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_long  = ($urandom_range(0, 2) == 0);
            iss_waddr = AW'($urandom_range(0, 7));
            ex_we = ($urandom_range(0, 1) == 1); ex_waddr = AW'($urandom_range(0, 7));
            ex_wdata = $urandom; ex_dvalid = ($urandom_range(0, 3) != 0);
            me_we = ($urandom_range(0, 1) == 1); me_waddr = AW'($urandom_range(0, 7));
            me_wdata = $urandom; me_dvalid = ($urandom_range(0, 3) != 0);
            wb_we = ($urandom_range(0, 1) == 1); wb_waddr = AW'($urandom_range(0, 7));
            wb_wdata = $urandom;
            lw_we = ($urandom_range(0, 3) == 0); lw_waddr = AW'($urandom_range(0, 7));
            lw_wdata = $urandom;
            if (wb_we && lw_we && wb_waddr == lw_waddr) begin
                lw_waddr = lw_waddr ^ AW'(1);
            end
            #2;
            est = 0;
            for (int p = 0; p < NR; p++) begin
                model_port(rd_addr[p*AW +: AW], rd_use[p], ed[p], es[p]);
                est = est | es[p];
                chk($sformatf("rnd%0d_p%0d_data", cyc, p), pdata(p), ed[p]);
            end
            chk($sformatf("rnd%0d_stall", cyc), {31'b0, stall}, {31'b0, est});
            if (lw_we && lw_waddr != 0) m_rf[lw_waddr] = lw_wdata;
            if (wb_we && wb_waddr != 0) m_rf[wb_waddr] = wb_wdata;
            if (lw_we) m_pend[lw_waddr] = 0;
            if (iss_valid && iss_long && !est && iss_waddr != 0) m_pend[iss_waddr] = 1;
        end

        @(negedge clk);
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
